// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory handshake, hazard/redirect controls
// and the IF/ID pipeline register outputs seen by decode.
interface instruction_fetch_unit_if;
    logic        i_mem_read;
    logic [31:0] i_mem_address;
    logic        i_mem_busywait;
    logic [31:0] i_mem_readdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_4_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    // fetch unit side
    modport master (
        output i_mem_read, i_mem_address,
        input  i_mem_busywait, i_mem_readdata,
        input  stall, redirect, redirect_target,
        output pc_out, pc_plus_4_out, instruction_out, valid_out
    );

    // memory / hazard unit / decode side
    modport slave (
        input  i_mem_read, i_mem_address,
        output i_mem_busywait, i_mem_readdata,
        output stall, redirect, redirect_target,
        input  pc_out, pc_plus_4_out, instruction_out, valid_out
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC, busywait memory handshake, one-entry hold
// buffer for stalls, and redirects that may land while a fetch is in flight.
//
// state | meaning
// FETCH | request at pc; deliver the word to IF/ID on completion
// DRAIN | redirect seen mid-request; wait out the old fetch, discard its data
// HOLD  | word fetched under stall is parked in hold_instr; no memory request
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_fetch_unit_if.master   bus
);
    typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] redirect_reg, redirect_reg_n;
    logic [31:0] hold_instr, hold_instr_n;
    logic [31:0] pc_out_n, pc_plus_4_out_n, instruction_out_n;
    logic        valid_out_n;
    logic        done;
    logic [31:0] target;

    assign target = bus.redirect_target & 32'hFFFF_FFFC;
    assign done   = bus.i_mem_read && !bus.i_mem_busywait;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_n;
    end

    // next-state and datapath next values
    always_comb begin
        state_n           = state;
        pc_n              = pc;
        redirect_reg_n    = redirect_reg;
        hold_instr_n      = hold_instr;
        pc_out_n          = bus.pc_out;
        pc_plus_4_out_n   = bus.pc_plus_4_out;
        instruction_out_n = bus.instruction_out;
        valid_out_n       = bus.valid_out;
        case (state)
            FETCH: begin
                if (done && bus.redirect) begin
                    pc_n              = target;
                    valid_out_n       = 1'b0;
                    instruction_out_n = NOP_INSTR;
                end else if (done && bus.stall) begin
                    hold_instr_n = bus.i_mem_readdata;
                    state_n      = HOLD;
                end else if (done) begin
                    pc_out_n          = pc;
                    pc_plus_4_out_n   = pc + 32'd4;
                    instruction_out_n = bus.i_mem_readdata;
                    valid_out_n       = 1'b1;
                    pc_n              = pc + 32'd4;
                end else if (bus.redirect) begin
                    redirect_reg_n    = target;
                    valid_out_n       = 1'b0;
                    instruction_out_n = NOP_INSTR;
                    state_n           = DRAIN;
                end else if (!bus.stall) begin
                    valid_out_n       = 1'b0;
                    instruction_out_n = NOP_INSTR;
                end
            end
            DRAIN: begin
                valid_out_n       = 1'b0;
                instruction_out_n = NOP_INSTR;
                if (bus.redirect) redirect_reg_n = target;
                if (done) begin
                    pc_n    = bus.redirect ? target : redirect_reg;
                    state_n = FETCH;
                end
            end
            HOLD: begin
                if (bus.redirect) begin
                    hold_instr_n      = NOP_INSTR;
                    pc_n              = target;
                    valid_out_n       = 1'b0;
                    instruction_out_n = NOP_INSTR;
                    state_n           = FETCH;
                end else if (!bus.stall) begin
                    pc_out_n          = pc;
                    pc_plus_4_out_n   = pc + 32'd4;
                    instruction_out_n = hold_instr;
                    valid_out_n       = 1'b1;
                    pc_n              = pc + 32'd4;
                    state_n           = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    // PC, side buffers and the IF/ID register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc                  <= RESET_PC;
            redirect_reg        <= 32'h0;
            hold_instr          <= NOP_INSTR;
            bus.pc_out          <= RESET_PC;
            bus.pc_plus_4_out   <= RESET_PC + 32'd4;
            bus.instruction_out <= NOP_INSTR;
            bus.valid_out       <= 1'b0;
        end else begin
            pc                  <= pc_n;
            redirect_reg        <= redirect_reg_n;
            hold_instr          <= hold_instr_n;
            bus.pc_out          <= pc_out_n;
            bus.pc_plus_4_out   <= pc_plus_4_out_n;
            bus.instruction_out <= instruction_out_n;
            bus.valid_out       <= valid_out_n;
        end
    end

    // memory request decode; address never moves while a request is open
    always_comb begin
        bus.i_mem_read    = (state != HOLD);
        bus.i_mem_address = pc;
    end
endmodule
